// File: rtl/cpu_out_uart_tx.sv
// CPU output port to 8N1 UART transmitter: a small byte FIFO feeding a
// start/data/stop serialiser, with tx driven from a flop.
module cpu_out_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpuOut,
  input  logic       out_valid,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_overflow;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;

  state_t      r_state;
  state_t      w_state_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_n;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_n;
  logic        r_tx;
  logic        w_tx_n;

  // Fullness is taken from the pointers before any same-edge pop.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign w_push  = out_valid && !w_full && !reset;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= cpuOut;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + (AW+1)'(1);
      end
      if (out_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

  // tx_n is the line level for the cycle after this edge, so each state
  // pre-loads the level of the slot it is about to enter.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rd[AW-1:0]];
          w_cnt_n   = CNT_RELOAD;
          w_tx_n    = 1'b0;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_cnt_n   = CNT_RELOAD;
          w_bit_n   = '0;
          w_tx_n    = r_shift[0];
          w_state_n = S_DATA;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_n = CNT_RELOAD;
          if (r_bit == 3'd7) begin
            w_tx_n    = 1'b1;
            w_state_n = S_STOP;
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      S_STOP: begin
        w_tx_n = 1'b1;
        if (r_cnt == '0) begin
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  assign tx        = r_tx;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;

endmodule
